// File: rtl/gray_ptr_sync.sv
// Multi-channel Gray pointer synchroniser into the clk domain with registered binary form.
// Define GRAY_PTR_SYNC_ERR_CHECK_EN to compile in the sticky multi-bit-jump monitor on err.
module gray_ptr_sync #(
    parameter int ADDRSIZE = 5,
    parameter int STAGES   = 2,
    parameter int CHANNELS = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               clear,
    input  logic [CHANNELS*(ADDRSIZE+1)-1:0]   ptr_gray,
    output logic [CHANNELS*(ADDRSIZE+1)-1:0]   ptr_sync,
    output logic [CHANNELS*(ADDRSIZE+1)-1:0]   ptr_bin,
    output logic [CHANNELS-1:0]                ptr_chg,
    output logic                               valid,
    output logic [CHANNELS-1:0]                err
);

    localparam int W  = ADDRSIZE + 1;
    localparam int CW = $clog2(STAGES + 2);
    localparam logic [CW-1:0] CNT_DONE = CW'(STAGES + 1);

    generate
        if (STAGES < 2) begin : g_bad_stages
            $error("gray_ptr_sync: STAGES must be at least 2");
        end
    endgenerate

    function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
        logic [W-1:0] b;
        b[W-1] = g[W-1];
        for (int i = W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [CHANNELS-1:0][STAGES-1:0][W-1:0] sync_q, sync_d;
    logic [CHANNELS-1:0][W-1:0]             prev_q, prev_d;
    logic [CHANNELS-1:0][W-1:0]             bin_q,  bin_d;
    logic [CHANNELS-1:0]                    chg_q,  chg_d;
    logic [CW-1:0]                          cnt_q,  cnt_d;
    logic                                   valid_q, valid_d;

    always_comb begin
        sync_d  = sync_q;
        prev_d  = prev_q;
        bin_d   = bin_q;
        chg_d   = '0;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        if (clear) begin
            sync_d  = '0;
            prev_d  = '0;
            bin_d   = '0;
            cnt_d   = '0;
            valid_d = 1'b0;
        end else begin
            cnt_d   = (cnt_q == CNT_DONE) ? cnt_q : cnt_q + 1'b1;
            // valid tracks the settle count so it holds once the count saturates
            valid_d = (cnt_d == CNT_DONE);
            for (int c = 0; c < CHANNELS; c++) begin
                sync_d[c][0] = ptr_gray[c*W +: W];
                for (int k = 1; k < STAGES; k++) begin
                    sync_d[c][k] = sync_q[c][k-1];
                end
                prev_d[c] = sync_q[c][STAGES-1];
                bin_d[c]  = gray2bin(sync_q[c][STAGES-1]);
                chg_d[c]  = (sync_q[c][STAGES-1] != prev_q[c]) && valid_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q  <= '0;
            prev_q  <= '0;
            bin_q   <= '0;
            chg_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            bin_q   <= bin_d;
            chg_q   <= chg_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        ptr_sync = '0;
        ptr_bin  = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            ptr_sync[c*W +: W] = sync_q[c][STAGES-1];
            ptr_bin[c*W +: W]  = bin_q[c];
        end
    end

    assign ptr_chg = chg_q;
    assign valid   = valid_q;

`ifdef GRAY_PTR_SYNC_ERR_CHECK_EN
    logic [CHANNELS-1:0] err_q, err_d;

    // A legal Gray step (including the wrap) flips exactly one bit.
    always_comb begin
        err_d = err_q;
        if (clear) begin
            err_d = '0;
        end else if (valid_q) begin
            for (int c = 0; c < CHANNELS; c++) begin
                if ($countones(sync_q[c][STAGES-1] ^ prev_q[c]) > 1) begin
                    err_d[c] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = '0;
`endif

endmodule

// File: tb/tb_gray_ptr_sync.sv
// Self-checking bench for gray_ptr_sync: history-based model compared every cycle plus literal checks.
module tb_gray_ptr_sync;

    localparam int ADDRSIZE = 3;
    localparam int STAGES   = 2;
    localparam int CHANNELS = 2;
    localparam int W        = ADDRSIZE + 1;

`ifdef GRAY_PTR_SYNC_ERR_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       clear;
    logic [7:0] ptr_gray;
    logic [7:0] ptr_sync;
    logic [7:0] ptr_bin;
    logic [1:0] ptr_chg;
    logic       valid;
    logic [1:0] err;

    always #5 clk = ~clk;

    gray_ptr_sync #(
        .ADDRSIZE(ADDRSIZE),
        .STAGES  (STAGES),
        .CHANNELS(CHANNELS)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .ptr_gray(ptr_gray),
        .ptr_sync(ptr_sync),
        .ptr_bin (ptr_bin),
        .ptr_chg (ptr_chg),
        .valid   (valid),
        .err     (err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] gray(input int i);
        logic [3:0] v;
        v = 4'(i);
        return v ^ (v >> 1);
    endfunction

    function automatic logic [3:0] g2b(input logic [3:0] g);
        return g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3);
    endfunction

    // Model: every input sample taken since the last reset/clear, indexed by edge number.
    logic [7:0] hist[$];
    int         n_m = 0;
    logic [1:0] err_m = '0;

    function automatic logic [3:0] smp(input int i, input int c);
        logic [7:0] v;
        v = hist[i-1];
        return v[c*4 +: 4];
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst || clear) begin
            hist.delete();
            n_m   <= 0;
            err_m <= '0;
        end else begin
            int         k;
            logic [1:0] e;
            hist.push_back(ptr_gray);
            k = n_m + 1;
            e = '0;
            if (k >= 4) begin
                for (int c = 0; c < 2; c++) begin
                    if ($countones(smp(k-2, c) ^ smp(k-3, c)) > 1) e[c] = 1'b1;
                end
            end
            n_m   <= k;
            err_m <= err_m | e;
        end
    end

    always @(posedge clk) begin
        logic [3:0] es, eb;
        logic       ec;
        #2;
        for (int c = 0; c < 2; c++) begin
            es = (n_m >= 2) ? smp(n_m-1, c) : 4'h0;
            eb = (n_m >= 3) ? g2b(smp(n_m-2, c)) : 4'h0;
            ec = (n_m >= 4) && (smp(n_m-2, c) != smp(n_m-3, c));
            check($sformatf("model_sync%0d", c), 32'(ptr_sync[c*4 +: 4]), 32'(es));
            check($sformatf("model_bin%0d", c),  32'(ptr_bin[c*4 +: 4]),  32'(eb));
            check($sformatf("model_chg%0d", c),  32'(ptr_chg[c]),         32'(ec));
        end
        check("model_valid", 32'(valid), 32'(n_m >= 3));
        check("model_err",   32'(err),   32'(ERR_EN ? err_m : 2'b00));
    end

    initial begin
        rst      = 1'b0;
        clear    = 1'b0;
        ptr_gray = 8'h00;
        #12;
        check("reset_sync",  32'(ptr_sync), 32'h0);
        check("reset_valid", 32'(valid),    32'h0);

        // Reset release with constant input on ch0
        @(negedge clk);
        ptr_gray = 8'h06;
        rst      = 1'b1;
        @(posedge clk); #2;
        check("pre_valid_chg", 32'(ptr_chg), 32'h0);
        check("pre_valid",     32'(valid),   32'h0);
        @(posedge clk); #2;
        check("sync_lat2",     32'(ptr_sync[3:0]), 32'b0110);
        check("valid_edge2",   32'(valid),         32'h0);
        @(posedge clk); #2;
        check("bin_lat3",      32'(ptr_bin[3:0]),  32'b0100);
        check("valid_edge3",   32'(valid),         32'h1);
        check("no_chg_edge3",  32'(ptr_chg),       32'h0);

        // Full Gray sequence with wrap on ch0
        @(negedge clk);
        clear    = 1'b1;
        ptr_gray = 8'h00;
        @(negedge clk);
        clear = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 1; i <= 16; i++) begin
            ptr_gray[3:0] = gray(i % 16);
            @(negedge clk);
        end
        repeat (2) @(posedge clk);
        #2;
        check("wrap_bin",  32'(ptr_bin[3:0]), 32'h0);
        check("wrap_err",  32'(err),          32'h0);

        // Illegal two-bit jump on ch1
        @(negedge clk);
        ptr_gray[7:4] = 4'b0011;
        @(posedge clk); #2;
        check("jump_err_e1", 32'(err[1]), 32'h0);
        @(posedge clk); #2;
        check("jump_err_e2", 32'(err[1]), 32'h0);
        @(posedge clk); #2;
        check("jump_err_e3",  32'(err[1]), 32'(ERR_EN));
        check("jump_err0_e3", 32'(err[0]), 32'h0);
        repeat (3) @(posedge clk);
        #2;
        check("jump_err_sticky", 32'(err[1]), 32'(ERR_EN));

        // Clear with 1010 in flight on ch0
        @(negedge clk);
        ptr_gray[3:0] = 4'b1010;
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk); #2;
        check("clr_sync",  32'(ptr_sync), 32'h0);
        check("clr_bin",   32'(ptr_bin),  32'h0);
        check("clr_chg",   32'(ptr_chg),  32'h0);
        check("clr_valid", 32'(valid),    32'h0);
        check("clr_err",   32'(err),      32'h0);
        @(negedge clk);
        clear = 1'b0;
        @(posedge clk); #2;
        @(posedge clk); #2;
        check("clr_valid_e2", 32'(valid), 32'h0);
        @(posedge clk); #2;
        check("clr_valid_e3", 32'(valid),         32'h1);
        check("clr_bin0",     32'(ptr_bin[3:0]),  32'b1100);
        check("clr_bin1",     32'(ptr_bin[7:4]),  32'b0010);
        check("clr_err_after",32'(err),           32'h0);

        // Asynchronous reset between edges
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        check("arst_sync",  32'(ptr_sync), 32'h0);
        check("arst_bin",   32'(ptr_bin),  32'h0);
        check("arst_chg",   32'(ptr_chg),  32'h0);
        check("arst_valid", 32'(valid),    32'h0);
        check("arst_err",   32'(err),      32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Channel independence: ch0 constant, ch1 counting
        repeat (4) @(negedge clk);
        for (int j = 0; j < 12; j++) begin
            ptr_gray[7:4] = gray(3 + j);
            @(posedge clk); #2;
            if (j >= 2) begin
                check("indep_chg",   32'(ptr_chg),       32'b10);
                check("indep_sync0", 32'(ptr_sync[3:0]), 32'b1010);
                check("indep_bin0",  32'(ptr_bin[3:0]),  32'b1100);
            end
            @(negedge clk);
        end

        repeat (3) @(posedge clk);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gray_ptr_sync.md
# gray_ptr_sync

Multi-channel, depth-configurable synchroniser for Gray-coded FIFO pointers crossing into the `clk` domain. Each channel passes through a `STAGES`-deep flop chain. The block then outputs both the synchronised Gray value and a registered Gray-to-binary conversion for full/empty and level arithmetic. It also provides a per-channel change strobe, a settled indication after reset/clear, and an optional multi-bit-jump error monitor. It sits on the read and write sides of the async FIFOs, one instance per destination domain, serving all pointers crossing into that domain.

## Interface
- `ADDRSIZE`, default 5: pointer address bits. Pointer width is W = `ADDRSIZE`+1.
- `STAGES`, default 2: synchroniser depth. Minimum 2; a smaller value is an elaboration error.
- `CHANNELS`, default 1: number of independent pointers.

- `clk`: input, 1 bit. Destination clock.
- `rst`: input, 1 bit. Asynchronous, active-low reset.
- `clear`: input, 1 bit. Synchronous clear, active-high.
- `ptr_gray`: input, CHANNELS*W bits. Source-domain Gray pointers. Channel c occupies `[c*W +: W]`.
- `ptr_sync`: output, CHANNELS*W bits. Synchronised Gray pointers, taken from the final stage.
- `ptr_bin`: output, CHANNELS*W bits. Registered binary form of `ptr_sync`.
- `ptr_chg`: output, CHANNELS bits. One-cycle strobe: `ptr_bin[c]` took a new value this cycle.
- `valid`: output, 1 bit. High once the pipeline holds only post-reset/clear samples.
- `err`: output, CHANNELS bits. Sticky flag: more than one bit changed between consecutive synchronised values.

## Operation
- Per channel, the registers are: stages s1..sSTAGES; previous-value register p; binary register b.
- Each edge without clear, the registers update as follows:
  - s1 ← ptr_gray
  - sk ← s(k-1)
  - p ← sSTAGES
  - b ← gray2bin(sSTAGES), where bin[W-1] = g[W-1] and bin[i] = bin[i+1] ^ g[i]
- `ptr_sync` = sSTAGES and `ptr_bin` = b.
- `ptr_chg[c]` is registered. It is set to (sSTAGES != p) && `valid`, so it is high in exactly the cycle `ptr_bin` shows the new value.
- Settle counter `cnt`, width clog2(STAGES+2):
  - Cleared to 0 by reset or clear.
  - Increments each edge until it reaches STAGES+1, then holds.
  - `valid` is a register that rises on the edge where `cnt` becomes STAGES+1.
- Error monitor: on each edge with `valid` already high, `err[c]` is set if popcount(sSTAGES ^ p) > 1.
  - `err` is sticky; only reset or clear de-asserts it.
  - A Gray wrap (e.g. 100..0 → 000..0) is a single-bit change and legal.
- Channels are fully independent. Only `cnt` and `valid` are shared.
- Reset (rst=0), asynchronous: all stages, p, b, `ptr_chg`, `cnt`, `valid` and `err` go to 0 immediately, regardless of clk.
- Clear (clear=1 at an edge): same zeroing at that edge. Clear has priority over all updates. Held clear keeps everything at 0.
- Reset or clear mid-stream discards in-flight samples. No stale value reaches the outputs after release.

## Timing
- Input to `ptr_sync`: STAGES edges.
- Input to `ptr_bin` and `ptr_chg`: STAGES+1 edges.
- `valid` rises STAGES+1 edges after reset/clear release. At that point `ptr_bin` reflects the first post-release input sample.
- `err` rises one edge after the offending value appears on `ptr_sync` (same edge as `ptr_bin` updates).
- All outputs are registered. There are no combinational paths from `ptr_gray` or `clear` to outputs.

## Configuration
- `GRAY_PTR_SYNC_ERR_CHECK_EN` defined: the popcount monitor and `err` registers are compiled in, as described above.
- Undefined: the monitor logic is absent and `err` is tied to 0. All other behaviour and latency are unchanged.

## Test plan
Configuration: ADDRSIZE=3, STAGES=2, CHANNELS=2, macro defined.

- **Reset then constant input.** Release rst, hold ch0 = 4'b0110 → `ptr_sync` ch0 = 0110 after 2 edges. After 3 edges, `ptr_bin` ch0 = 0100 and `valid` = 1. No `ptr_chg` before `valid`.
- **Full Gray sequence with wrap.** Gray count 0..15 then 0, one step per cycle on ch0 → `ptr_bin` follows 0,1,…,15,0 with 3-cycle latency. `ptr_chg[0]` = 1 every cycle. `err` = 0.
- **Illegal jump.** With `valid` = 1, step ch1 from 0000 to 0011 → `err[1]` = 1 at the 3rd edge and stays set. `err[0]` = 0.
- **Clear mid-stream.** Pulse clear with ch0 = 1010 in flight → at that edge all outputs = 0 and `valid` = 0. `valid` returns 3 edges after clear drops. `err` is cleared.
- **Async reset between edges.** Drop rst mid-cycle → all outputs 0 before the next clk edge.
- **Channel independence.** Ch0 constant, ch1 incrementing → `ptr_chg` = 2'b10 each cycle. Ch0 outputs are unchanged.
